// File: rtl/cpu_gen.sv
// Minimal accumulator CPU: A/B/OUT registers, carry flag, jumps and a HALT state.
// Define CPU_GEN_ZERO_FLAG_EN to add the zero flag and the JZ instruction (opcode 12).
module cpu_gen #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic [3:0]        opecode,
   input  logic [DATA_W-1:0] imm,
   input  logic              instr_valid,
   input  logic [DATA_W-1:0] switch,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] led,
   output logic              halted
);

   localparam logic ST_RUN  = 1'b0;
   localparam logic ST_HALT = 1'b1;

   logic              state_reg, state_next;
   logic [DATA_W-1:0] a_reg, a_next;
   logic [DATA_W-1:0] b_reg, b_next;
   logic [DATA_W-1:0] out_reg, out_next;
   logic [ADDR_W-1:0] ip_reg, ip_next;
   logic              cf_reg, cf_next;
`ifdef CPU_GEN_ZERO_FLAG_EN
   logic              zf_reg, zf_next;
`endif

   logic [DATA_W:0]   add_a, add_b;
   logic [DATA_W-1:0] sub_a;
   logic [ADDR_W-1:0] ip_inc, jmp_target;

   // Carry is the bit beyond DATA_W of a zero-extended sum
   assign add_a      = {1'b0, a_reg} + {1'b0, imm};
   assign add_b      = {1'b0, b_reg} + {1'b0, imm};
   assign sub_a      = a_reg - imm;
   assign ip_inc     = ip_reg + ADDR_W'(1);
   assign jmp_target = imm[ADDR_W-1:0];

   always_comb begin
      state_next = state_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      out_next   = out_reg;
      ip_next    = ip_reg;
      cf_next    = cf_reg;
`ifdef CPU_GEN_ZERO_FLAG_EN
      zf_next    = zf_reg;
`endif
      if (state_reg == ST_RUN && instr_valid) begin
         ip_next = ip_inc;
         cf_next = 1'b0;
`ifdef CPU_GEN_ZERO_FLAG_EN
         zf_next = 1'b0;
`endif
         case (opecode)
            4'd0: begin
               a_next  = add_a[DATA_W-1:0];
               cf_next = add_a[DATA_W];
`ifdef CPU_GEN_ZERO_FLAG_EN
               zf_next = (add_a[DATA_W-1:0] == '0);
`endif
            end
            4'd1: b_next = a_reg;
            4'd2: a_next = switch;
            4'd3: a_next = imm;
            4'd4: a_next = b_reg;
            4'd5: begin
               b_next  = add_b[DATA_W-1:0];
               cf_next = add_b[DATA_W];
`ifdef CPU_GEN_ZERO_FLAG_EN
               zf_next = (add_b[DATA_W-1:0] == '0);
`endif
            end
            4'd6: b_next = switch;
            4'd7: b_next = imm;
            4'd8: begin
               a_next  = sub_a;
               cf_next = (a_reg < imm);
`ifdef CPU_GEN_ZERO_FLAG_EN
               zf_next = (sub_a == '0);
`endif
            end
            4'd9:  out_next = b_reg;
            4'd10: out_next = a_reg;
            4'd11: out_next = imm;
`ifdef CPU_GEN_ZERO_FLAG_EN
            4'd12: if (zf_reg) ip_next = jmp_target;
`endif
            4'd13: begin
               state_next = ST_HALT;
               ip_next    = ip_reg;
            end
            // Flags tested here are the values held before this instruction
            4'd14: if (!cf_reg) ip_next = jmp_target;
            4'd15: ip_next = jmp_target;
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_reg <= ST_RUN;
         a_reg     <= '0;
         b_reg     <= '0;
         out_reg   <= '0;
         ip_reg    <= '0;
         cf_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         out_reg   <= out_next;
         ip_reg    <= ip_next;
         cf_reg    <= cf_next;
      end
   end

`ifdef CPU_GEN_ZERO_FLAG_EN
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) zf_reg <= 1'b0;
      else        zf_reg <= zf_next;
   end
`endif

   assign addr   = ip_reg;
   assign led    = out_reg;
   assign halted = (state_reg == ST_HALT);

endmodule

// File: tb/tb_cpu_gen.sv
// Bench for cpu_gen: a 4-bit/4-bit and an 8-bit/6-bit instance checked against an arithmetic model.
module tb_cpu_gen;

`ifdef CPU_GEN_ZERO_FLAG_EN
   localparam bit ZF_EN = 1'b1;
`else
   localparam bit ZF_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;

   logic [3:0] op0 = '0, imm0 = '0, sw0 = '0;
   logic       v0 = 1'b0;
   logic [3:0] addr0, led0;
   logic       halted0;

   logic [3:0] op1 = '0;
   logic [7:0] imm1 = '0, sw1 = '0;
   logic       v1 = 1'b0;
   logic [5:0] addr1;
   logic [7:0] led1;
   logic       halted1;

   int checks = 0;
   int errors = 0;

   // Reference model state, index 0 = 4/4 instance, 1 = 8/6 instance
   int ma[2], mb[2], mo[2], mip[2], mcf[2], mzf[2], mh[2];
   int dw[2] = '{4, 8};
   int aw[2] = '{4, 6};

   always #5 clk = ~clk;

   cpu_gen #(.DATA_W(4), .ADDR_W(4)) dut0 (
      .clk(clk), .n_rst(n_rst), .opecode(op0), .imm(imm0), .instr_valid(v0),
      .switch(sw0), .addr(addr0), .led(led0), .halted(halted0)
   );

   cpu_gen #(.DATA_W(8), .ADDR_W(6)) dut1 (
      .clk(clk), .n_rst(n_rst), .opecode(op1), .imm(imm1), .instr_valid(v1),
      .switch(sw1), .addr(addr1), .led(led1), .halted(halted1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] get_addr(input int w);
      return (w == 0) ? 32'(addr0) : 32'(addr1);
   endfunction
   function automatic logic [31:0] get_led(input int w);
      return (w == 0) ? 32'(led0) : 32'(led1);
   endfunction
   function automatic logic [31:0] get_halted(input int w);
      return (w == 0) ? 32'(halted0) : 32'(halted1);
   endfunction

   task automatic model_reset();
      for (int w = 0; w < 2; w++) begin
         ma[w] = 0; mb[w] = 0; mo[w] = 0; mip[w] = 0; mcf[w] = 0; mzf[w] = 0; mh[w] = 0;
      end
   endtask

   task automatic model_step(input int w, input int op, input int im, input int sw, input bit valid);
      int m, am, s, nip, ncf, nzf;
      if (mh[w] != 0 || !valid) return;
      m   = 1 << dw[w];
      am  = 1 << aw[w];
      im  = im % m;
      sw  = sw % m;
      nip = (mip[w] + 1) % am;
      ncf = 0;
      nzf = 0;
      case (op)
         0: begin s = ma[w] + im; ma[w] = s % m; ncf = (s >= m); nzf = (ma[w] == 0); end
         1: mb[w] = ma[w];
         2: ma[w] = sw;
         3: ma[w] = im;
         4: ma[w] = mb[w];
         5: begin s = mb[w] + im; mb[w] = s % m; ncf = (s >= m); nzf = (mb[w] == 0); end
         6: mb[w] = sw;
         7: mb[w] = im;
         8: begin ncf = (ma[w] < im); ma[w] = (ma[w] - im + m) % m; nzf = (ma[w] == 0); end
         9:  mo[w] = mb[w];
         10: mo[w] = ma[w];
         11: mo[w] = im;
         12: if (ZF_EN && mzf[w] != 0) nip = im % am;
         13: begin mh[w] = 1; nip = mip[w]; end
         14: if (mcf[w] == 0) nip = im % am;
         15: nip = im % am;
         default: ;
      endcase
      mip[w] = nip;
      mcf[w] = ncf;
      mzf[w] = ZF_EN ? nzf : 0;
   endtask

   task automatic check_dut(input int w, input string tag);
      check({tag, "_addr"},   get_addr(w),   32'(mip[w]));
      check({tag, "_led"},    get_led(w),    32'(mo[w]));
      check({tag, "_halted"}, get_halted(w), 32'(mh[w]));
   endtask

   // Called at posedge+1; executes one cycle on instance w and checks it
   task automatic exec(input int w, input int op, input int im, input int sw, input bit valid, input string tag);
      v0 = 1'b0; v1 = 1'b0;
      if (w == 0) begin
         op0 = 4'(op); imm0 = 4'(im); sw0 = 4'(sw); v0 = valid;
      end else begin
         op1 = 4'(op); imm1 = 8'(im); sw1 = 8'(sw); v1 = valid;
      end
      @(posedge clk);
      #1;
      model_step(w, op, im, sw, valid);
      check_dut(w, tag);
   endtask

   // Pulses reset between clock edges and checks the outputs clear without a clock
   task automatic do_reset(input string tag);
      v0 = 1'b0; v1 = 1'b0;
      #2;
      n_rst = 1'b0;
      #1;
      model_reset();
      check_dut(0, tag);
      check_dut(1, tag);
      @(negedge clk);
      n_rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int w, op, im, sw, exp_addr;
      bit valid;
      model_reset();
      @(posedge clk);
      #1;
      check_dut(0, "rst_hold0");
      check_dut(1, "rst_hold1");
      @(negedge clk);
      n_rst = 1'b1;
      @(posedge clk);
      #1;

      // Add with carry out, then JNC must fall through
      exec(0, 3, 9, 0, 1'b1, "lda9");
      exec(0, 0, 7, 0, 1'b1, "add7");
      exec(0, 14, 5, 0, 1'b1, "jnc_fall");
      check("jnc_fall_const", 32'(addr0), 32'd3);
      exec(0, 10, 0, 0, 1'b1, "out_a0");
      check("out_a0_const", 32'(led0), 32'd0);

      // 8-bit subtraction with and without borrow
      exec(1, 3, 'h10, 0, 1'b1, "lda10");
      exec(1, 8, 'h11, 0, 1'b1, "sub11");
      exec(1, 14, 'h20, 0, 1'b1, "jnc_borrow");
      exec(1, 10, 0, 0, 1'b1, "out_ff");
      check("sub_ff_const", 32'(led1), 32'hFF);
      exec(1, 3, 'h10, 0, 1'b1, "lda10b");
      exec(1, 8, 'h0F, 0, 1'b1, "sub0f");
      exec(1, 14, 'h20, 0, 1'b1, "jnc_taken");
      check("jnc_taken_const", 32'(addr1), 32'h20);
      exec(1, 10, 0, 0, 1'b1, "out_01");
      check("sub_01_const", 32'(led1), 32'h01);
      exec(1, 15, 'h7A, 0, 1'b1, "jmp_trunc");
      check("jmp_trunc_const", 32'(addr1), 32'h3A);

      // IP wrap after 16 NOPs, then a JMP
      do_reset("rst_wrap");
      for (int i = 0; i < 16; i++) exec(0, 12, 0, 0, 1'b1, "nop");
      check("wrap_const", 32'(addr0), 32'd0);
      exec(0, 15, 'hA, 0, 1'b1, "jmp_a");

      // Stall cycles hold everything
      exec(0, 2, 0, 6, 1'b1, "in_sw");
      exec(0, 1, 0, 0, 1'b1, "b_a");
      for (int i = 0; i < 3; i++) exec(0, $urandom_range(0, 15), $urandom, $urandom, 1'b0, "stall");
      exec(0, 9, 0, 0, 1'b1, "out_b");
      exec(0, 5, 'hF, 0, 1'b1, "addb");
      exec(0, 9, 0, 0, 1'b1, "out_b2");

      // HALT at address 4 holds for 10 cycles regardless of instr_valid
      do_reset("rst_halt");
      for (int i = 0; i < 4; i++) exec(0, 11, i + 1, 0, 1'b1, "pre_halt");
      exec(0, 13, 0, 0, 1'b1, "halt");
      for (int i = 0; i < 10; i++) exec(0, $urandom_range(0, 15), $urandom, $urandom, 1'($urandom), "in_halt");
      check("halt_addr_const", 32'(addr0), 32'd4);
      do_reset("rst_from_halt");

      // Zero result followed by JZ
      exec(0, 3, 3, 0, 1'b1, "lda3");
      exec(0, 0, 13, 0, 1'b1, "add13");
      exec(0, 12, 9, 0, 1'b1, "jz9");
      exp_addr = ZF_EN ? 9 : 3;
      check("jz_const", 32'(addr0), 32'(exp_addr));

      // Randomised instruction stream on both instances
      for (int i = 0; i < 400; i++) begin
         if (i % 50 == 49) do_reset("rst_rand");
         w     = $urandom_range(0, 1);
         op    = $urandom_range(0, 15);
         if (op == 13 && $urandom_range(0, 3) != 0) op = 12;
         im    = $urandom_range(0, 255);
         sw    = $urandom_range(0, 255);
         valid = ($urandom_range(0, 4) != 0);
         exec(w, op, im, sw, valid, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
